// File: rtl/ddr_pkg.sv
// Shared types and helpers for the DDR hit-judgement engine.
package ddr_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        PERFECT = 2'd1,
        GOOD    = 2'd2,
        MISS    = 2'd3
    } judge_t;

    localparam int DEF_PERFECT_WIN = 2;
    localparam int DEF_GOOD_WIN    = 6;

    // Unsigned add that clamps at lim instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[31:0];
    endfunction

endpackage

// File: rtl/judge_fifo.sv
// Per-lane queue of pending note target ticks; head is visible combinationally.
module judge_fifo
    import ddr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TW    = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [TW-1:0] data_i,
    input  logic          pop_i,
    output logic [TW-1:0] head_o,
    output logic          empty_o,
    output logic          full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [TW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty_o   = (r_count == '0);
    assign full_o    = (r_count == (AW+1)'(DEPTH));
    assign head_o    = r_mem[r_rd_ptr];
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

endmodule

// File: rtl/ddr_judge.sv
// N-lane hit judgement and scoring: times presses against queued note targets,
// accumulates score/combo/life and latches game-over.
module ddr_judge
    import ddr_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int DEPTH       = 4,
    parameter int TW          = 10,
    parameter int PERFECT_WIN = DEF_PERFECT_WIN,
    parameter int GOOD_WIN    = DEF_GOOD_WIN,
    parameter int SCORE_W     = 16,
    parameter int LIFE_W      = 6,
    parameter int LIFE_MAX    = 32,
    parameter int LIFE_GAIN   = 1,
    parameter int LIFE_LOSS   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     tick_i,
    input  logic [LANES-1:0]         btn_i,
    input  logic                     note_valid_i,
    input  logic [$clog2(LANES)-1:0] note_lane_i,
    input  logic [TW-1:0]            note_tick_i,
    output logic                     note_ready_o,
    output logic [2*LANES-1:0]       judge_o,
    output logic [SCORE_W-1:0]       score_o,
    output logic [SCORE_W-1:0]       combo_o,
    output logic [SCORE_W-1:0]       max_combo_o,
    output logic [LIFE_W-1:0]        life_o,
    output logic                     game_over_o,
    output logic [TW-1:0]            song_tick_o
);
    localparam int          LW        = $clog2(LANES);
    localparam int          CW        = $clog2(LANES + 1);
    localparam logic [31:0] SCORE_SAT = 32'({SCORE_W{1'b1}});

    logic [TW-1:0]      r_song_tick;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_combo;
    logic [SCORE_W-1:0] r_max_combo;
    logic [LIFE_W-1:0]  r_life;
    logic               r_game_over;
    judge_t             r_judge [LANES];

    logic [TW-1:0]      w_head [LANES];
    logic [LANES-1:0]   w_empty, w_full, w_push, w_pop;
    logic [LANES-1:0]   w_perf, w_good, w_miss, w_stray;
    logic [CW-1:0]      w_n_perf, w_n_good, w_n_miss, w_n_stray;
    logic [SCORE_W-1:0] w_score_next, w_combo_next, w_max_next;
    logic [LIFE_W-1:0]  w_life_next;
    int                 w_life_sum;

    assign note_ready_o = !w_full[note_lane_i] && !r_game_over;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        logic [TW-1:0] w_diff;
        logic [TW-1:0] w_abs;
        logic          w_late;
        logic          w_hit;

        // diff is read as signed: positive means the target has already passed.
        assign w_diff     = r_song_tick - w_head[n];
        assign w_abs      = w_diff[TW-1] ? (~w_diff + 1'b1) : w_diff;
        assign w_late     = !w_diff[TW-1] && (w_diff > TW'(GOOD_WIN));
        assign w_miss[n]  = !r_game_over && !w_empty[n] && w_late;
        assign w_hit      = !r_game_over && btn_i[n] && !w_empty[n] && !w_late;
        assign w_perf[n]  = w_hit && (w_abs <= TW'(PERFECT_WIN));
        assign w_good[n]  = w_hit && (w_abs > TW'(PERFECT_WIN)) && (w_abs <= TW'(GOOD_WIN));
        assign w_stray[n] = !r_game_over && btn_i[n] && !w_perf[n] && !w_good[n];
        assign w_pop[n]   = w_miss[n] || w_perf[n] || w_good[n];
        assign w_push[n]  = note_valid_i && note_ready_o && (note_lane_i == LW'(n));
        assign judge_o[2*n +: 2] = r_judge[n];

        judge_fifo #(
            .DEPTH(DEPTH),
            .TW   (TW)
        ) u_fifo (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .push_i (w_push[n]),
            .data_i (note_tick_i),
            .pop_i  (w_pop[n]),
            .head_o (w_head[n]),
            .empty_o(w_empty[n]),
            .full_o (w_full[n])
        );
    end

    always_comb begin
        w_n_perf  = '0;
        w_n_good  = '0;
        w_n_miss  = '0;
        w_n_stray = '0;
        for (int i = 0; i < LANES; i++) begin
            w_n_perf  = w_n_perf  + CW'(w_perf[i]);
            w_n_good  = w_n_good  + CW'(w_good[i]);
            w_n_miss  = w_n_miss  + CW'(w_miss[i]);
            w_n_stray = w_n_stray + CW'(w_stray[i]);
        end
    end

    always_comb begin
        w_score_next = SCORE_W'(sat_add(32'(r_score),
                                        32'({w_n_perf, 1'b0}) + 32'(w_n_good), SCORE_SAT));
        if ((w_n_miss != '0) || (w_n_stray != '0))
            w_combo_next = '0;
        else
            w_combo_next = SCORE_W'(sat_add(32'(r_combo),
                                            32'(w_n_perf) + 32'(w_n_good), SCORE_SAT));
        w_max_next = (w_combo_next > r_max_combo) ? w_combo_next : r_max_combo;

        w_life_sum = int'(r_life) + int'(w_n_perf) * LIFE_GAIN - int'(w_n_miss) * LIFE_LOSS;
        if (w_life_sum < 0)
            w_life_next = '0;
        else if (w_life_sum > LIFE_MAX)
            w_life_next = LIFE_W'(LIFE_MAX);
        else
            w_life_next = LIFE_W'(w_life_sum);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_song_tick <= '0;
            r_score     <= '0;
            r_combo     <= '0;
            r_max_combo <= '0;
            r_life      <= LIFE_W'(LIFE_MAX);
            r_game_over <= 1'b0;
            for (int i = 0; i < LANES; i++) r_judge[i] <= NONE;
        end else begin
            if (tick_i) r_song_tick <= r_song_tick + 1'b1;
            for (int i = 0; i < LANES; i++)
                r_judge[i] <= w_perf[i] ? PERFECT : w_good[i] ? GOOD : w_miss[i] ? MISS : NONE;
            // Once over, everything but the song tick stays frozen until reset.
            if (!r_game_over) begin
                r_score     <= w_score_next;
                r_combo     <= w_combo_next;
                r_max_combo <= w_max_next;
                r_life      <= w_life_next;
                r_game_over <= (w_life_next == '0);
            end
        end
    end

    assign score_o     = r_score;
    assign combo_o     = r_combo;
    assign max_combo_o = r_max_combo;
    assign life_o      = r_life;
    assign game_over_o = r_game_over;
    assign song_tick_o = r_song_tick;

endmodule
